cpu_datapath: RTL and testbench
===============================

# cpu_datapath

Register-and-ALU datapath that sits on the receiving end of the CPU controller's control word. Each cycle it decodes `Tristate`, `Enable`, `ALUOp` and `InstrBus` to pick one bus driver, latches bus data into the enabled registers and runs ALU operations. It holds four general registers (R0–R3), ALU operand/result registers, flags and the store output register that drives the board display.

## Interface
Parameters:
- `WIDTH`, 8: data width of the bus and of every register.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `clr`  in  1: reset, synchronous, active-high; driven from the controller's `clearRegs`.
- `Tristate`  in  6: bus-driver select. Bit 0–3 = R0–R3, bit 4 = ALU result, bit 5 = immediate.
- `Enable`  in  7: load strobes. Bit 0–3 = R0–R3, bit 4 = ALU A, bit 5 = ALU execute, bit 6 = store output.
- `ALUOp`  in  2: ALU function. Sampled only while `Enable[5]` is high.
- `InstrBus`  in  4: instruction low nibble. Source of the immediate.
- `bus`  out  WIDTH: resolved internal bus value, combinational.
- `out_reg`  out  WIDTH: store output register.
- `r0`, `r1`, `r2`, `r3`  out  WIDTH: register contents, for display and debug.
- `carry`  out  1: carry/borrow flag.
- `zero`  out  1: zero flag.
- `conflict_err`  out  1: sticky bus-conflict flag.

## Operation
- The bus is a mux, with no real tristates. It selects the driver of the lowest-numbered asserted `Tristate` bit. Immediate = `{(WIDTH-4)'b0, InstrBus}`. No driver gives bus = 0.
- `Enable[0..3]`: Rn <= bus. Several enables in one cycle all load the same bus value. A register that drives and loads itself keeps its value.
- `Enable[4]`: A <= bus.
- `Enable[5]`: operand B = bus, taken combinationally and not stored. The result register, `carry` and `zero` update from `ALUOp`:
  - 00: A+B, carry = carry-out.
  - 01: A−B, carry = 1 when A<B (borrow).
  - 10: A&B, carry = 0.
  - 11: A|B, carry = 0.
  - `zero` = (WIDTH-bit result == 0). Results wrap modulo 2^WIDTH.
- `Enable[6]`: out_reg <= bus.
- `Enable[4]` and `Enable[5]` together: the result uses the old A; A still loads the bus value on the same edge.
- `Enable[5]` with `Tristate[4]`: the result register is both source and destination. The result uses the old result value as B.
- Flags hold their value except on an `Enable[5]` edge.
- Conflict detection: two or more `Tristate` bits high in one cycle set `conflict_err` on that edge. It stays set until `clr`.

## Timing
- The bus is valid in the same cycle that `Tristate` is asserted, with no registered stage.
- Every load takes 1 cycle: the strobe is sampled at the rising edge and the register output is valid right after that edge.
- A full ALU sequence takes 3 controller cycles (ALUin, ALUexec, ALUout). The result is readable on the bus during ALUout, the cycle after `Enable[5]`.
- Reset: on a rising edge with `clr` = 1, the following go to 0 in the same edge:
  - r0–r3, A, result, out_reg
  - carry, zero, conflict_err
- `clr` overrides all `Enable` bits in that cycle. A reset in the middle of an ALU sequence drops the operation, and a later ALUout drives 0.
- The `bus` output carries no reset value: it follows `Tristate` combinationally, so the registers read 0 after reset.

## Configuration
- `CPU_DATAPATH_BUS_CHECK_EN`
  - Defined: conflict detection is built as described.
  - Not defined: `conflict_err` is tied to 0 and no detection logic is generated. Bus priority resolution works the same either way.

## Test plan
- Load immediate: `InstrBus`=0x5, `Tristate`=6'b100000, `Enable`=7'b0000001 for 1 cycle -> r0 = 0x05 after the edge; bus = 0x05 during the cycle.
- Add with carry: r0 = 0xFE, r1 = 0x03. Drive ALUin (`Tristate[0]`, `Enable[4]`), then ALUexec (`Tristate[1]`, `Enable[5]`, `ALUOp`=00), then ALUout (`Tristate[4]`, `Enable[2]`). Expect r2 = 0x01, carry = 1, zero = 0.
- Subtract with borrow and zero: A = 0x03, B = 0x05, `ALUOp`=01 -> result 0xFE, carry = 1. Then A = 0x07, B = 0x07 -> result 0x00, zero = 1, carry = 0.
- Store: r3 = 0xA5, `Tristate[3]` + `Enable[6]` -> out_reg = 0xA5; r3 unchanged.
- Conflict: r0 = 0x11, r1 = 0x22, `Tristate`=6'b000011, `Enable[2]` -> bus = 0x11, r2 = 0x11.
  - With the macro defined: conflict_err = 1 and stays 1 through later clean cycles.
  - Without the macro: conflict_err = 0.
- Reset mid-operation: `clr` = 1 in the same cycle as `Enable`=7'b1111111 and an immediate of 0xF -> all registers and flags read 0 next cycle. Then drive ALUout without ALUexec -> bus = 0x00.

Source files
------------

// File: rtl/cpu_datapath.sv
// cpu_datapath: four general registers, ALU with A/result/flags, store register.
// Optional bus-conflict detection is built when CPU_DATAPATH_BUS_CHECK_EN is defined.
module cpu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [5:0]       Tristate,
  input  logic [6:0]       Enable,
  input  logic [1:0]       ALUOp,
  input  logic [3:0]       InstrBus,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] out_reg,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic             carry,
  output logic             zero,
  output logic             conflict_err
);

  logic [WIDTH-1:0] gpr [4];
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] imm;
  logic [WIDTH:0]   alu_full;

  assign imm = {{(WIDTH-4){1'b0}}, InstrBus};
  assign r0  = gpr[0];
  assign r1  = gpr[1];
  assign r2  = gpr[2];
  assign r3  = gpr[3];

  // Bus mux: lowest-numbered asserted driver wins, none drives zero.
  always_comb begin
    bus = '0;
    if (Tristate[0])      bus = gpr[0];
    else if (Tristate[1]) bus = gpr[1];
    else if (Tristate[2]) bus = gpr[2];
    else if (Tristate[3]) bus = gpr[3];
    else if (Tristate[4]) bus = res;
    else if (Tristate[5]) bus = imm;
  end

  // ALU: B is the live bus; top bit holds carry-out or borrow.
  always_comb begin
    alu_full = '0;
    case (ALUOp)
      2'b00: alu_full = {1'b0, a} + {1'b0, bus};
      2'b01: alu_full = {1'b0, a} - {1'b0, bus};
      2'b10: alu_full = {1'b0, a & bus};
      default: alu_full = {1'b0, a | bus};
    endcase
  end

  // General registers and store register load from the bus.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4; i++) gpr[i] <= '0;
      out_reg <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (Enable[i]) gpr[i] <= bus;
      if (Enable[6]) out_reg <= bus;
    end
  end

  // ALU state: A, result and flags; the result sees the pre-edge A.
  always_ff @(posedge clk) begin
    if (clr) begin
      a     <= '0;
      res   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      if (Enable[4]) a <= bus;
      if (Enable[5]) begin
        res   <= alu_full[WIDTH-1:0];
        carry <= (ALUOp[1] == 1'b0) ? alu_full[WIDTH] : 1'b0;
        zero  <= (alu_full[WIDTH-1:0] == '0);
      end
    end
  end

`ifdef CPU_DATAPATH_BUS_CHECK_EN
  logic multi;
  assign multi = |(Tristate & (Tristate - 6'd1));

  // Sticky flag: set whenever two or more drivers are selected.
  always_ff @(posedge clk) begin
    if (clr)        conflict_err <= 1'b0;
    else if (multi) conflict_err <= 1'b1;
  end
`else
  assign conflict_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: scoreboard bench for cpu_datapath.
// Directed sequences then random control words against a reference model.
module tb_cpu_datapath;

  localparam int W = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         clr;
  logic [5:0]   Tristate;
  logic [6:0]   Enable;
  logic [1:0]   ALUOp;
  logic [3:0]   InstrBus;
  logic [W-1:0] bus, out_reg, r0, r1, r2, r3;
  logic         carry, zero, conflict_err;

  cpu_datapath #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .Tristate(Tristate), .Enable(Enable),
    .ALUOp(ALUOp), .InstrBus(InstrBus), .bus(bus), .out_reg(out_reg),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .carry(carry), .zero(zero),
    .conflict_err(conflict_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bus;
    int r [4];
    int outv;
    int c;
    int z;
    int cerr;
  } exp_t;

  exp_t q [$];
  int checks = 0;
  int errors = 0;
  bit done = 0;

  // reference model state
  int m_r [4];
  int m_a, m_res, m_out, m_c, m_z, m_cerr;

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  task automatic step(input bit c, input logic [5:0] ts, input logic [6:0] en,
                      input logic [1:0] op, input logic [3:0] ib);
    int drv [6];
    int b, y, nc;
    exp_t e;
    @(posedge clk);
    #1;
    clr = c; Tristate = ts; Enable = en; ALUOp = op; InstrBus = ib;
    drv[0] = m_r[0]; drv[1] = m_r[1]; drv[2] = m_r[2]; drv[3] = m_r[3];
    drv[4] = m_res;  drv[5] = int'(ib);
    b = 0;
    for (int i = 5; i >= 0; i--) if (ts[i]) b = drv[i];
    e.bus = b;
    if (c) begin
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_a = 0; m_res = 0; m_out = 0; m_c = 0; m_z = 0; m_cerr = 0;
    end else begin
      if (en[5]) begin
        case (op)
          2'd0: begin y = m_a + b; nc = (y > MASK) ? 1 : 0; end
          2'd1: begin y = m_a - b; nc = (m_a < b) ? 1 : 0; end
          2'd2: begin y = m_a & b; nc = 0; end
          default: begin y = m_a | b; nc = 0; end
        endcase
        m_res = y & MASK; m_c = nc; m_z = (m_res == 0) ? 1 : 0;
      end
      for (int i = 0; i < 4; i++) if (en[i]) m_r[i] = b;
      if (en[4]) m_a = b;
      if (en[6]) m_out = b;
`ifdef CPU_DATAPATH_BUS_CHECK_EN
      if ($countones(ts) >= 2) m_cerr = 1;
`endif
    end
    e.r = m_r; e.outv = m_out; e.c = m_c; e.z = m_z; e.cerr = m_cerr;
    q.push_back(e);
  endtask

  // monitor: bus mid-cycle, then state just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("bus", int'(bus), e.bus);
        @(posedge clk);
        #1;
        chk("r0", int'(r0), e.r[0]);
        chk("r1", int'(r1), e.r[1]);
        chk("r2", int'(r2), e.r[2]);
        chk("r3", int'(r3), e.r[3]);
        chk("out_reg", int'(out_reg), e.outv);
        chk("carry", int'(carry), e.c);
        chk("zero", int'(zero), e.z);
        chk("conflict_err", int'(conflict_err), e.cerr);
      end
    end
  end

  initial begin
    clr = 1'b1; Tristate = '0; Enable = '0; ALUOp = '0; InstrBus = '0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_a = 0; m_res = 0; m_out = 0; m_c = 0; m_z = 0; m_cerr = 0;
    step(1, 6'b0, 7'b0, 2'd0, 4'h0);
    // load immediate
    step(0, 6'b100000, 7'b0000001, 2'd0, 4'h5);
    // r0 = 0 - 2 = 0xFE, r1 = 3, then add into r2
    step(0, 6'b000000, 7'b0010000, 2'd0, 4'h0);
    step(0, 6'b100000, 7'b0100000, 2'd1, 4'h2);
    step(0, 6'b010000, 7'b0000001, 2'd0, 4'h0);
    step(0, 6'b100000, 7'b0000010, 2'd0, 4'h3);
    step(0, 6'b000001, 7'b0010000, 2'd0, 4'h0);
    step(0, 6'b000010, 7'b0100000, 2'd0, 4'h0);
    step(0, 6'b010000, 7'b0000100, 2'd0, 4'h0);
    // subtract with borrow, then to zero
    step(0, 6'b100000, 7'b0010000, 2'd0, 4'h3);
    step(0, 6'b100000, 7'b0100000, 2'd1, 4'h5);
    step(0, 6'b100000, 7'b0010000, 2'd0, 4'h7);
    step(0, 6'b100000, 7'b0100000, 2'd1, 4'h7);
    // A load and exec on the same edge; result as its own B
    step(0, 6'b100000, 7'b0110000, 2'd0, 4'h9);
    step(0, 6'b010000, 7'b0100000, 2'd0, 4'h0);
    // store r2 via r3
    step(0, 6'b000100, 7'b0001000, 2'd0, 4'h0);
    step(0, 6'b001000, 7'b1000000, 2'd0, 4'h0);
    // conflict
    step(0, 6'b100000, 7'b0000001, 2'd0, 4'h1);
    step(0, 6'b100000, 7'b0000010, 2'd0, 4'h2);
    step(0, 6'b000011, 7'b0000100, 2'd0, 4'h0);
    step(0, 6'b100000, 7'b0000000, 2'd0, 4'h0);
    // self-load keeps value
    step(0, 6'b000010, 7'b0000010, 2'd0, 4'h0);
    // reset mid-operation, then ALUout
    step(0, 6'b100000, 7'b0010000, 2'd0, 4'hC);
    step(1, 6'b100000, 7'b1111111, 2'd3, 4'hF);
    step(0, 6'b010000, 7'b0000001, 2'd0, 4'h0);
    // random control words
    for (int n = 0; n < 400; n++) begin
      logic [5:0] ts;
      ts = 6'($urandom);
      if ($urandom_range(0, 3) != 0) ts = 6'(1 << $urandom_range(0, 5));
      step(($urandom_range(0, 40) == 0), ts, 7'($urandom),
           2'($urandom), 4'($urandom));
    end
    step(0, 6'b0, 7'b0, 2'd0, 4'h0);
    repeat (4) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
